// File: rtl/apb_interconnect.sv
// APB address decoder/interconnect: one master, NUM_SLAVES slaves, with a wait-state
// watchdog, PSLVERR on unmapped or timed-out transfers, and a saturating error counter.
module apb_interconnect #(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_psel,
  input  logic                         m_penable,
  input  logic                         m_pwrite,
  input  logic [ADDR_W-1:0]            m_paddr,
  input  logic [DATA_W-1:0]            m_pwdata,
  output logic [DATA_W-1:0]            m_prdata,
  output logic                         m_pready,
  output logic                         m_pslverr,
  output logic [NUM_SLAVES-1:0]        s_psel,
  output logic                         s_penable,
  output logic                         s_pwrite,
  output logic [ADDR_W-1:0]            s_paddr,
  output logic [DATA_W-1:0]            s_pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]        s_pready,
  input  logic [NUM_SLAVES-1:0]        s_pslverr,
  output logic [15:0]                  err_count,
  output logic                         timeout_p
);

  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d, cur_idx;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [15:0]        err_count_d;
  logic               mapped, sel_ready, sel_err, tmo;
  logic [DATA_W-1:0]  sel_rdata;

  assign s_penable = m_penable & (state_q == ACCESS) & ~reset;
  assign s_pwrite  = m_pwrite;
  assign s_paddr   = m_paddr;
  assign s_pwdata  = m_pwdata;

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wait_cnt  <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_cnt  <= wait_cnt_d;
      err_count <= err_count_d;
    end
  end

  // Decode, response mux, watchdog and next-state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt;
    err_count_d = err_count;
    s_psel      = '0;
    sel_ready   = 1'b0;
    sel_err     = 1'b0;
    sel_rdata   = '0;
    m_pready    = 1'b0;
    m_pslverr   = 1'b0;
    m_prdata    = '0;
    timeout_p   = 1'b0;

    // SETUP decodes the live address; ACCESS holds the latched index
    cur_idx = (state_q == ACCESS) ? idx_q : m_paddr[ADDR_W-1 -: SEL_W];
    mapped  = 32'(cur_idx) < NUM_SLAVES;

    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (cur_idx == SEL_W'(i)) begin
        s_psel[i] = m_psel & ~reset;
        sel_ready = s_pready[i];
        sel_err   = s_pslverr[i];
        sel_rdata = s_prdata[i*DATA_W +: DATA_W];
      end
    end

    // A slave ready in the last allowed cycle beats the watchdog
    tmo = (TIMEOUT > 0) && mapped && !sel_ready && (wait_cnt == CNT_W'(TMO_LAST));

    if (state_q == ACCESS && !reset) begin
      if (!mapped) begin
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
      end else if (tmo) begin
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
        timeout_p = 1'b1;
      end else begin
        m_pready  = sel_ready;
        m_pslverr = sel_err;
        m_prdata  = sel_rdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (m_psel && !m_penable) begin
          state_d    = ACCESS;
          idx_d      = m_paddr[ADDR_W-1 -: SEL_W];
          wait_cnt_d = '0;
        end
      end
      ACCESS: begin
        if (m_pready) begin
          state_d = IDLE;
          if (m_pslverr && err_count != 16'hFFFF) err_count_d = err_count + 16'd1;
        end else if (!sel_ready) begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_interconnect.sv
// Scoreboard bench for apb_interconnect: directed transfers push expected completions,
// a monitor compares every m_pready completion against the queue.
module tb_apb_interconnect;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_psel, m_penable, m_pwrite;
  logic [15:0] m_paddr, m_pwdata, m_prdata;
  logic        m_pready, m_pslverr;
  logic [2:0]  s_psel;
  logic        s_penable, s_pwrite;
  logic [15:0] s_paddr, s_pwdata;
  logic [47:0] s_prdata;
  logic [2:0]  s_pready, s_pslverr;
  logic [15:0] err_count;
  logic        timeout_p;

  typedef struct {
    logic [15:0] rdata;
    logic        slverr;
    logic        tmo;
    int          ncyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   wait_cfg [3];
  int   acc_n = 0;
  int   mon_n = 0;

  apb_interconnect #(.NUM_SLAVES(3), .ADDR_W(16), .DATA_W(16), .SEL_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .err_count(err_count), .timeout_p(timeout_p)
  );

  always #5 clk = ~clk;

  assign s_prdata = {16'h2222, 16'h1111, 16'h1234};

  // Slave model: ready once the current ACCESS has lasted wait_cfg[i] cycles
  always @(posedge clk) begin
    if (s_penable && (|s_psel) && !m_pready) acc_n <= acc_n + 1;
    else acc_n <= 0;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) s_pready[i] = (acc_n >= wait_cfg[i]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_psel && m_penable) mon_n++;
      else mon_n = 0;
      if (m_pready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("prdata", 32'(m_prdata), 32'(e.rdata));
          chk("pslverr", 32'(m_pslverr), 32'(e.slverr));
          chk("timeout_p", 32'(timeout_p), 32'(e.tmo));
          chk("access_cycles", 32'(mon_n), 32'(e.ncyc));
        end
      end
    end
  end

  task automatic expect_done(input logic [15:0] rd, input logic se, input logic tm, input int n);
    exp_t e;
    e.rdata = rd; e.slverr = se; e.tmo = tm; e.ncyc = n;
    sb.push_back(e);
  endtask

  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                      input logic [2:0] exp_sel);
    int n;
    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr; m_pwdata = data;
    @(negedge clk);
    chk("setup_psel", 32'(s_psel), 32'(exp_sel));
    chk("setup_penable", 32'(s_penable), 32'd0);
    chk("setup_paddr", 32'(s_paddr), 32'(addr));
    @(posedge clk); #1;
    m_penable = 1'b1;
    @(negedge clk);
    chk("access_psel", 32'(s_psel), 32'(exp_sel));
    chk("access_penable", 32'(s_penable), 32'd1);
    n = 0;
    while (!m_pready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("completed_in_budget", 32'(m_pready), 32'd1);
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge clk);
    chk("psel_dropped", 32'(s_psel), 32'd0);
  endtask

  initial begin
    wait_cfg[0] = 0; wait_cfg[1] = 0; wait_cfg[2] = 0;
    s_pslverr = 3'b000;
    reset = 1'b1;
    m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b0; m_paddr = 16'h4000; m_pwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", 32'(s_psel), 32'd0);
    chk("rst_penable", 32'(s_penable), 32'd0);
    chk("rst_pready", 32'(m_pready), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_timeout_p", 32'(timeout_p), 32'd0);
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0; reset = 1'b0;

    // Write to slave 1, zero wait states
    expect_done(16'h1111, 1'b0, 1'b0, 1);
    xfer(1'b1, 16'h4010, 16'hBEEF, 3'b010);
    chk("wr_pwdata_passthru", 32'(s_pwdata), 32'h0000BEEF);

    // Read slave 0 with three wait states
    wait_cfg[0] = 3;
    expect_done(16'h1234, 1'b0, 1'b0, 4);
    xfer(1'b0, 16'h0004, 16'h0, 3'b001);
    chk("err_count_after_read", 32'(err_count), 32'd0);

    // Unmapped index 3
    expect_done(16'h0000, 1'b1, 1'b0, 1);
    xfer(1'b0, 16'hC000, 16'h0, 3'b000);
    chk("err_count_unmapped", 32'(err_count), 32'd1);

    // Slave 2 never ready: watchdog on 8th ACCESS cycle
    wait_cfg[2] = 1000;
    expect_done(16'h0000, 1'b1, 1'b1, 8);
    xfer(1'b0, 16'h8000, 16'h0, 3'b100);
    chk("err_count_timeout", 32'(err_count), 32'd2);

    // Slave ready on exactly the timeout cycle wins
    wait_cfg[2] = 7;
    expect_done(16'h2222, 1'b0, 1'b0, 8);
    xfer(1'b0, 16'h8002, 16'h0, 3'b100);
    chk("err_count_race", 32'(err_count), 32'd2);

    // Slave-signalled error
    s_pslverr = 3'b010;
    expect_done(16'h1111, 1'b1, 1'b0, 1);
    xfer(1'b0, 16'h4000, 16'h0, 3'b010);
    chk("err_count_slverr", 32'(err_count), 32'd3);
    s_pslverr = 3'b000;

    // penable without SETUP is ignored
    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b1; m_paddr = 16'h4000;
    repeat (2) begin
      @(negedge clk);
      chk("violation_penable", 32'(s_penable), 32'd0);
      chk("violation_pready", 32'(m_pready), 32'd0);
    end
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0;

    // Reset in the middle of an ACCESS wait
    wait_cfg[0] = 1000;
    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 16'h0000;
    @(posedge clk); #1;
    m_penable = 1'b1;
    repeat (3) @(negedge clk);
    chk("midxfer_psel", 32'(s_psel), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_psel", 32'(s_psel), 32'd0);
    chk("midrst_penable", 32'(s_penable), 32'd0);
    chk("midrst_pready", 32'(m_pready), 32'd0);
    chk("midrst_pslverr", 32'(m_pslverr), 32'd0);
    chk("midrst_prdata", 32'(m_prdata), 32'd0);
    @(negedge clk);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
    wait_cfg[0] = 0;

    expect_done(16'h1234, 1'b0, 1'b0, 1);
    xfer(1'b0, 16'h0004, 16'h0, 3'b001);
    chk("err_count_post_reset", 32'(err_count), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got stall want finish");
    $fatal(1);
  end

endmodule
